instr_fetch: RTL and testbench

- Instruction fetch stage sitting between the program ROM and the decode/control unit.
- Holds the program counter and drives the ROM address. The ROM is combinational, so data is returned in the same cycle.
- Captures the returned word into an instruction register and presents it to decode with a valid/ready handshake.
- Resolves unconditional JMP locally, halts on STOP, and accepts redirects from execute.

---
 rtl/instr_fetch_if.sv | 30 +++
 rtl/instr_fetch.sv | 100 ++++++++++
 tb/tb_instr_fetch.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// ============================================================================
// instr_fetch_if : ROM, decode-handshake, redirect and halt signals of fetch
// Revision 1.0
// ============================================================================
`default_nettype none

interface instr_fetch_if;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic [15:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redir_valid;
  logic [7:0]  redir_addr;
  logic        resume;
  logic        halted;

  modport master (
    output rom_addr, instr, instr_pc, instr_valid, halted,
    input  rom_data, instr_ready, redir_valid, redir_addr, resume
  );

  modport slave (
    input  rom_addr, instr, instr_pc, instr_valid, halted,
    output rom_data, instr_ready, redir_valid, redir_addr, resume
  );
endinterface

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================================
// instr_fetch : PC, ROM addressing, instruction register with valid/ready,
//               local JMP folding, STOP/HALT and execute redirects
// Revision 1.0
// ============================================================================
`default_nettype none

module instr_fetch #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter bit         FOLD_JMP = 1'b1
) (
  input  wire logic     clk,
  input  wire logic     rst,
  instr_fetch_if.master bus
);

  localparam logic [4:0] c_OPC_JMP  = 5'h0C;
  localparam logic [4:0] c_OPC_STOP = 5'h1F;

  localparam logic [0:0] c_S_FETCH = 1'b0;
  localparam logic [0:0] c_S_HALT  = 1'b1;

  logic [7:0]  pc_q,       pc_d;
  logic [15:0] instr_q,    instr_d;
  logic [7:0]  instr_pc_q, instr_pc_d;
  logic        valid_q,    valid_d;
  logic [0:0]  state_q,    state_d;
  logic        halted_q,   halted_d;

  logic        w_load;
  logic        w_redirect;
  logic [4:0]  w_opcode;

  assign w_opcode   = bus.rom_data[15:11];
  assign w_redirect = (state_q == c_S_FETCH) && bus.redir_valid;
  assign w_load     = (state_q == c_S_FETCH) && (!valid_q || bus.instr_ready)
                      && !bus.redir_valid;

  always_comb begin
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    state_d    = state_q;

    if (w_redirect) begin
      // The held word is discarded even if decode takes it this cycle.
      pc_d    = bus.redir_addr;
      valid_d = 1'b0;
    end else if (w_load) begin
      instr_d    = bus.rom_data;
      instr_pc_d = pc_q;
      valid_d    = 1'b1;
      if (FOLD_JMP && (w_opcode == c_OPC_JMP)) begin
        pc_d = bus.rom_data[7:0];
      end else begin
        pc_d = pc_q + 8'd1;
      end
      if (w_opcode == c_OPC_STOP) begin
        state_d = c_S_HALT;
      end
    end else if (valid_q && bus.instr_ready) begin
      valid_d = 1'b0;
    end

    if (halted_q && bus.resume) begin
      state_d = c_S_FETCH;
    end

    // Computed from next-state values so halted always tracks HALT && empty.
    halted_d = (state_d == c_S_HALT) && !valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      instr_q    <= 16'h0000;
      instr_pc_q <= 8'h00;
      valid_q    <= 1'b0;
      state_q    <= c_S_FETCH;
      halted_q   <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      state_q    <= state_d;
      halted_q   <= halted_d;
    end
  end

  assign bus.rom_addr    = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = valid_q;
  assign bus.halted      = halted_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
// tb_instr_fetch : directed scenarios plus a randomized program/handshake run
//                  checked against an instruction-stream reference model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch;

  localparam logic [4:0] c_NOP  = 5'h00;
  localparam logic [4:0] c_LDS  = 5'h01;
  localparam logic [4:0] c_STS  = 5'h02;
  localparam logic [4:0] c_JMP  = 5'h0C;
  localparam logic [4:0] c_STOP = 5'h1F;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] rom [256];
  int n_checks = 0;
  int n_fails  = 0;

  instr_fetch_if bus ();

  assign bus.rom_data = rom[bus.rom_addr];

  instr_fetch #(.RESET_PC(8'h00), .FOLD_JMP(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mk(input logic [4:0] op, input logic [2:0] r,
                                     input logic [7:0] a);
    return {op, r, a};
  endfunction

  // Program-order successor of the word at a, as seen by decode.
  function automatic logic [7:0] next_addr(input logic [7:0] a);
    logic [15:0] w;
    w = rom[a];
    if (w[15:11] == c_JMP) return w[7:0];
    return a + 8'd1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
  endtask

  task automatic load_loop_prog();
    clear_rom();
    rom[0] = mk(c_LDS, 3'd0, 8'h81);
    rom[1] = mk(c_STS, 3'd0, 8'h80);
    rom[2] = mk(c_STS, 3'd0, 8'h83);
    rom[3] = mk(c_JMP, 3'd0, 8'h00);
    rom[4] = mk(c_STOP, 3'd0, 8'h00);
    rom[5] = mk(c_LDS, 3'd1, 8'h55);
  endtask

  task automatic do_reset();
    bus.instr_ready = 1'b0;
    bus.redir_valid = 1'b0;
    bus.redir_addr  = 8'h00;
    bus.resume      = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    load_loop_prog();
    do_reset();
    n_checks++;
    if (bus.instr_valid !== 1'b0) begin
      n_fails++; $display("FAIL reset_valid: got %b expected 0", bus.instr_valid);
    end
    n_checks++;
    if (bus.instr !== 16'h0000 || bus.instr_pc !== 8'h00) begin
      n_fails++; $display("FAIL reset_instr: got %h/%h expected 0000/00", bus.instr, bus.instr_pc);
    end
    n_checks++;
    if (bus.halted !== 1'b0 || bus.rom_addr !== 8'h00) begin
      n_fails++; $display("FAIL reset_halt_addr: got halted=%b addr=%h expected 0/00", bus.halted, bus.rom_addr);
    end
  endtask

  task automatic test_loop();
    load_loop_prog();
    do_reset();
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_checks++;
      if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'(i % 4) || bus.instr !== rom[i % 4]) begin
        n_fails++;
        $display("FAIL loop[%0d]: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                 i, bus.instr_valid, bus.instr_pc, bus.instr, 8'(i % 4), rom[i % 4]);
      end
    end
  endtask

  task automatic test_stall();
    load_loop_prog();
    do_reset();
    bus.instr_ready = 1'b1;
    tick();
    tick();
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'h01 || bus.instr !== rom[1]
          || bus.rom_addr !== 8'h02) begin
        n_fails++;
        $display("FAIL stall_hold[%0d]: got v=%b pc=%h instr=%h addr=%h expected 1/01/%h/02",
                 i, bus.instr_valid, bus.instr_pc, bus.instr, bus.rom_addr, rom[1]);
      end
    end
    bus.instr_ready = 1'b1;
    tick();
    n_checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'h02) begin
      n_fails++; $display("FAIL stall_release: got v=%b pc=%h expected 1/02", bus.instr_valid, bus.instr_pc);
    end
  endtask

  task automatic test_stop();
    load_loop_prog();
    do_reset();
    bus.instr_ready = 1'b1;
    tick();
    bus.redir_valid = 1'b1;
    bus.redir_addr  = 8'h04;
    tick();
    bus.redir_valid = 1'b0;
    bus.instr_ready = 1'b0;
    tick();
    n_checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'h04 || bus.instr !== rom[4]
        || bus.halted !== 1'b0 || bus.rom_addr !== 8'h05) begin
      n_fails++;
      $display("FAIL stop_present: got v=%b pc=%h instr=%h halted=%b addr=%h expected 1/04/%h/0/05",
               bus.instr_valid, bus.instr_pc, bus.instr, bus.halted, bus.rom_addr, rom[4]);
    end
    bus.instr_ready = 1'b1;
    tick();
    n_checks++;
    if (bus.instr_valid !== 1'b0 || bus.halted !== 1'b1 || bus.rom_addr !== 8'h05) begin
      n_fails++;
      $display("FAIL stop_halted: got v=%b halted=%b addr=%h expected 0/1/05",
               bus.instr_valid, bus.halted, bus.rom_addr);
    end
    bus.redir_valid = 1'b1;
    bus.redir_addr  = 8'h00;
    tick();
    bus.redir_valid = 1'b0;
    tick();
    n_checks++;
    if (bus.instr_valid !== 1'b0 || bus.halted !== 1'b1 || bus.rom_addr !== 8'h05) begin
      n_fails++;
      $display("FAIL halt_ignore_redir: got v=%b halted=%b addr=%h expected 0/1/05",
               bus.instr_valid, bus.halted, bus.rom_addr);
    end
    bus.resume = 1'b1;
    tick();
    bus.resume = 1'b0;
    n_checks++;
    if (bus.halted !== 1'b0 || bus.instr_valid !== 1'b0) begin
      n_fails++; $display("FAIL resume_exit: got halted=%b v=%b expected 0/0", bus.halted, bus.instr_valid);
    end
    tick();
    n_checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'h05 || bus.instr !== rom[5]) begin
      n_fails++;
      $display("FAIL resume_fetch: got v=%b pc=%h instr=%h expected 1/05/%h",
               bus.instr_valid, bus.instr_pc, bus.instr, rom[5]);
    end
  endtask

  task automatic test_redirect_drop();
    load_loop_prog();
    do_reset();
    bus.instr_ready = 1'b1;
    tick();
    bus.redir_valid = 1'b1;
    bus.redir_addr  = 8'h02;
    tick();
    bus.redir_valid = 1'b0;
    n_checks++;
    if (bus.instr_valid !== 1'b0) begin
      n_fails++; $display("FAIL redir_bubble: got v=%b expected 0", bus.instr_valid);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'((2 + i) % 4)) begin
        n_fails++;
        $display("FAIL redir_seq[%0d]: got v=%b pc=%h expected 1/%h",
                 i, bus.instr_valid, bus.instr_pc, 8'((2 + i) % 4));
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp;
    clear_rom();
    do_reset();
    bus.instr_ready = 1'b1;
    bus.redir_valid = 1'b1;
    bus.redir_addr  = 8'hFE;
    tick();
    bus.redir_valid = 1'b0;
    exp = 8'hFE;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (bus.instr_valid !== 1'b1 || bus.instr_pc !== exp) begin
        n_fails++;
        $display("FAIL wrap[%0d]: got v=%b pc=%h expected 1/%h", i, bus.instr_valid, bus.instr_pc, exp);
      end
      exp = exp + 8'd1;
    end
  endtask

  task automatic test_reset_in_halt();
    load_loop_prog();
    do_reset();
    bus.redir_valid = 1'b1;
    bus.redir_addr  = 8'h04;
    tick();
    bus.redir_valid = 1'b0;
    tick();
    tick();
    n_checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'h04 || bus.halted !== 1'b0) begin
      n_fails++;
      $display("FAIL halt_setup: got v=%b pc=%h halted=%b expected 1/04/0",
               bus.instr_valid, bus.instr_pc, bus.halted);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (bus.instr_valid !== 1'b0 || bus.halted !== 1'b0 || bus.rom_addr !== 8'h00) begin
      n_fails++;
      $display("FAIL halt_reset: got v=%b halted=%b addr=%h expected 0/0/00",
               bus.instr_valid, bus.halted, bus.rom_addr);
    end
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'(i)) begin
        n_fails++;
        $display("FAIL halt_reset_fetch[%0d]: got v=%b pc=%h expected 1/%h",
                 i, bus.instr_valid, bus.instr_pc, 8'(i));
      end
    end
  endtask

  // Random JMP-laden programs, random ready and occasional redirects; the
  // model only knows program order, so it tracks the next address decode sees.
  task automatic test_random();
    logic [7:0]  exp;
    logic [15:0] held_instr;
    logic [7:0]  held_pc;
    logic        redir, held, exp_valid;
    logic [4:0]  ops [4];
    ops[0] = c_NOP; ops[1] = c_LDS; ops[2] = c_STS; ops[3] = c_JMP;
    for (int i = 0; i < 256; i++) begin
      rom[i] = mk(($urandom_range(0, 7) == 0) ? c_JMP : ops[$urandom_range(0, 2)],
                  3'($urandom), 8'($urandom));
    end
    do_reset();
    exp       = 8'h00;
    exp_valid = 1'b0;
    held      = 1'b0;
    held_instr = 16'h0;
    held_pc    = 8'h0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      bus.instr_ready = ($urandom_range(0, 3) != 0);
      redir           = ($urandom_range(0, 15) == 0);
      bus.redir_valid = redir;
      bus.redir_addr  = 8'($urandom);
      #1;
      if (redir) begin
        exp  = bus.redir_addr;
        held = 1'b0;
      end else if (exp_valid && bus.instr_ready) begin
        n_checks++;
        if (bus.instr_pc !== exp || bus.instr !== rom[exp]) begin
          n_fails++;
          $display("FAIL rand_consume[%0d]: got pc=%h instr=%h expected %h/%h",
                   cyc, bus.instr_pc, bus.instr, exp, rom[exp]);
        end
        exp  = next_addr(exp);
        held = 1'b0;
      end else if (exp_valid) begin
        held       = 1'b1;
        held_instr = bus.instr;
        held_pc    = bus.instr_pc;
      end else begin
        held = 1'b0;
      end
      tick();
      exp_valid = !redir;
      n_checks++;
      if (bus.instr_valid !== exp_valid) begin
        n_fails++; $display("FAIL rand_valid[%0d]: got %b expected %b", cyc, bus.instr_valid, exp_valid);
      end
      if (held) begin
        n_checks++;
        if (bus.instr !== held_instr || bus.instr_pc !== held_pc) begin
          n_fails++;
          $display("FAIL rand_hold[%0d]: got %h/%h expected %h/%h",
                   cyc, bus.instr, bus.instr_pc, held_instr, held_pc);
        end
      end
    end
  endtask

  initial begin
    bus.instr_ready = 1'b0;
    bus.redir_valid = 1'b0;
    bus.redir_addr  = 8'h00;
    bus.resume      = 1'b0;
    clear_rom();
    test_reset();
    test_loop();
    test_stall();
    test_stop();
    test_redirect_drop();
    test_wrap();
    test_reset_in_halt();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
